mem_arbiter_2port: RTL and testbench
====================================

MEM_ARBITER_2PORT -- requirements
Module: mem_arbiter_2port

Interface
REQ-001 The block SHALL have parameter DW, default 64, for the data width of requests, responses and the memory data bus.
REQ-002 The block SHALL have parameter AW, default 2, for the address width (4 banks).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: port clk (input, 1, rising-edge clock) and port rst_n (input, 1, asynchronous active-low reset).
REQ-004 The block SHALL have these requester ports, with n = 0 or 1:
- reqn_valid  input  1  request present
- reqn_we  input  1  1 = write, 0 = read
- reqn_addr  input  AW  bank address
- reqn_wdata  input  DW  write data
- reqn_ready  output  1  request accepted this cycle
- rspn_valid  output  1  one-cycle completion pulse
- rspn_rdata  output  DW  read data, valid while rspn_valid is high
REQ-005 The block SHALL have these memory-side ports:
- mem_wr_en  output  1  write strobe
- mem_wr_addr  output  AW  write address
- mem_din  output  DW  write data
- mem_rd_en  output  1  read strobe
- mem_rd_addr  output  AW  read address
- mem_dout  input  DW  registered read data, valid the cycle after mem_rd_en
- mem_full  input  1  memory not accepting
REQ-006 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-007 The block SHALL implement the states IDLE, ISSUE, CAPT and RESP.
REQ-008 In IDLE with mem_full=0 and at least one reqn_valid, the block SHALL assert exactly one reqn_ready (the grant), combinationally from the valids and the arbitration state.
REQ-009 No reqn_ready SHALL be asserted outside IDLE, or in IDLE while mem_full=1.
REQ-010 On acceptance (reqn_valid & reqn_ready), the block SHALL latch we, addr, wdata and the requester id, then go to ISSUE.
REQ-011 ISSUE SHALL last exactly one cycle and drive exactly one strobe from the latched command: mem_wr_en with mem_wr_addr/mem_din for a write, or mem_rd_en with mem_rd_addr for a read.
REQ-012 After ISSUE, a write SHALL go to RESP and a read SHALL go to CAPT.
REQ-013 In CAPT, the block SHALL register mem_dout into the granted requester's rdata register, then go to RESP.
REQ-014 RESP SHALL last one cycle, pulse the granted requester's rspn_valid, then return to IDLE.
REQ-015 A write SHALL leave rspn_rdata unchanged.
REQ-016 Latency SHALL be measured from the acceptance edge T: ISSUE at T+1, write RESP at T+2, read CAPT at T+2, read RESP at T+3.
REQ-017 The next acceptance SHALL be possible no earlier than the cycle after RESP.
REQ-018 rsp0_valid and rsp1_valid SHALL never be high in the same cycle.
REQ-019 mem_wr_en and mem_rd_en SHALL never be high in the same cycle.
REQ-020 All outputs except reqn_ready SHALL be registered.
REQ-021 The memory address SHALL be taken unmodified from the latched AW-bit address, with no range check (all 4 values legal).
REQ-022 A requester that drops reqn_valid before it is granted SHALL lose nothing; no request is queued.

Reset
REQ-023 While rst_n=0, the block SHALL be in IDLE.
REQ-024 While rst_n=0, all strobes, rspn_valid and busy SHALL be 0, rspn_rdata SHALL be 0, and the last-grant register SHALL be 1.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately (asynchronously): no strobe and no response is emitted for it afterwards.
REQ-026 After reset deassertion, the first grant with both requesters valid SHALL go to requester 0.

Configuration
REQ-027 With MEMARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not granted last, and the last-grant register updates on each acceptance.
REQ-028 Without MEMARB_RR_EN, arbitration SHALL be fixed priority (requester 0 always wins) and the last-grant register SHALL be absent.
REQ-029 In both builds, a single valid requester SHALL always be granted (subject to REQ-009).

Verification
REQ-030 Bench scenario: req0 writes addr 2, data 64'h1122334455667788, then req0 reads addr 2 -> write rsp0_valid at T+2; read rsp0_rdata=64'h1122334455667788 at T+3.
REQ-031 Bench scenario: both requesters hold valid reads for 4 grants with MEMARB_RR_EN defined -> grant order 0,1,0,1; without the macro -> 0,0,0,0.
REQ-032 Bench scenario: mem_full=1 for 5 cycles with req1_valid=1 -> req1_ready stays 0 and no strobe; acceptance occurs in the first cycle after mem_full falls.
REQ-033 Bench scenario: rst_n pulsed low during CAPT of a read -> no rsp asserted; outputs 0; busy=0; the next request completes normally.
REQ-034 Bench scenario: write to each of addr 0-3 with distinct data, then read back all 4 -> each read returns its own data, and mem_wr_en/mem_rd_en are never both high.

Source files
------------

// File: rtl/mem_arbiter_2port.sv
// Two-requester arbiter onto a single-port bank memory; one command in flight. Optional MEMARB_RR_EN: round-robin grant, else req0 fixed priority.
// Latency: accept T, strobe T+1, write rsp T+2, read data + rsp T+3.
// Backpressure: reqN_ready only in IDLE with mem_full low; nothing is queued.
module mem_arbiter_2port #(
    parameter int DW = 64,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_full,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t        state, state_nxt;
    logic          cmd_we;
    logic          cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          grant1;
    logic          can_grant;
    logic          accept;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef MEMARB_RR_EN
    logic last_grant;

    // Reset value 1 makes requester 0 win the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end

    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
`else
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign can_grant  = (state == IDLE) & ~mem_full;
    assign req0_ready = can_grant & req0_valid & ~grant1;
    assign req1_ready = can_grant & grant1;
    assign accept     = req0_ready | req1_ready;

    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = cmd_we ? RESP : CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            cmd_we    <= sel_we;
            cmd_id    <= grant1;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
        end
    end

    // Memory address/data come straight from the command registers.
    assign mem_wr_addr = cmd_addr;
    assign mem_rd_addr = cmd_addr;
    assign mem_din     = cmd_wdata;

    // Strobes and responses are registered off the next state so they line up with ISSUE/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            mem_wr_en  <= accept & sel_we;
            mem_rd_en  <= accept & ~sel_we;
            rsp0_valid <= (state_nxt == RESP) & ~cmd_id;
            rsp1_valid <= (state_nxt == RESP) & cmd_id;
            busy       <= (state_nxt != IDLE);
            if (state == CAPT) begin
                if (cmd_id)
                    rsp1_rdata <= mem_dout;
                else
                    rsp0_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed bench for mem_arbiter_2port with a 4-bank registered-read memory model.
module tb_mem_arbiter_2port;
    localparam int DW = 64;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic          mem_wr_en, mem_rd_en, mem_full, busy;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] bank_data [4] = '{64'h1111_0000_0000_00A0, 64'h2222_0000_0000_00B1,
                                     64'h3333_0000_0000_00C2, 64'h4444_0000_0000_00D3};

    always #5 clk = ~clk;

    mem_arbiter_2port #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout),
        .mem_full(mem_full), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_din;
        if (mem_rd_en) mem_dout <= mem[mem_rd_addr];
    end

    always @(negedge clk) begin
        if (rst_n && ((mem_wr_en && mem_rd_en) || (rsp0_valid && rsp1_valid)))
            viol++;
    end

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rspv(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [DW-1:0] rdat(input int p);
        return (p == 0) ? rsp0_rdata : rsp1_rdata;
    endfunction

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One full transaction on port p with cycle-exact checks of strobe, response and idle return.
    task automatic txn(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int n;
        logic [DW-1:0] prev;
        prev = rdat(p);
        @(negedge clk);
        drive(p, 1'b1, we, a, d);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (rdy(p) !== 1'b1) begin
            errors++; $display("FAIL txn_grant p=%0d got ready=%b want 1", p, rdy(p));
        end
        @(negedge clk);
        drive(p, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (we ? !(mem_wr_en === 1'b1 && mem_rd_en === 1'b0 && mem_wr_addr === a && mem_din === d)
               : !(mem_rd_en === 1'b1 && mem_wr_en === 1'b0 && mem_rd_addr === a)) begin
            errors++;
            $display("FAIL txn_issue p=%0d we=%b got wr=%b rd=%b wa=%0d ra=%0d din=%h want addr=%0d din=%h",
                     p, we, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_din, a, d);
        end
        checks++;
        if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL txn_busy got busy=%b rdy=%b%b want 1,00", busy, req0_ready, req1_ready);
        end
        @(negedge clk); #1;
        if (we) begin
            checks++;
            if (rspv(p) !== 1'b1 || rspv(1-p) !== 1'b0 || rdat(p) !== prev) begin
                errors++;
                $display("FAIL txn_wr_rsp p=%0d got v=%b other=%b rdata=%h want 1,0,%h",
                         p, rspv(p), rspv(1-p), rdat(p), prev);
            end
        end else begin
            checks++;
            if (rspv(p) !== 1'b0) begin
                errors++; $display("FAIL txn_rd_capt p=%0d got rsp_valid=%b want 0", p, rspv(p));
            end
            @(negedge clk); #1;
            checks++;
            if (rspv(p) !== 1'b1 || rspv(1-p) !== 1'b0 || rdat(p) !== exp_rd) begin
                errors++;
                $display("FAIL txn_rd_rsp p=%0d got v=%b other=%b rdata=%h want 1,0,%h",
                         p, rspv(p), rspv(1-p), rdat(p), exp_rd);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL txn_done got rsp=%b%b busy=%b want 00,0", rsp0_valid, rsp1_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mem_full = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 ||
            rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b wr=%b rd=%b rsp=%b%b rd0=%h rd1=%h want all 0",
                     busy, mem_wr_en, mem_rd_en, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        txn(0, 1'b1, 2'd2, 64'h1122334455667788, '0);
        txn(0, 1'b0, 2'd2, '0, 64'h1122334455667788);
    endtask

    task automatic test_all_banks;
        for (int a = 0; a < 4; a++)
            txn(a % 2, 1'b1, a[AW-1:0], bank_data[a], '0);
        for (int a = 0; a < 4; a++)
            txn((a + 1) % 2, 1'b0, a[AW-1:0], '0, bank_data[a]);
    endtask

    task automatic test_arbitration;
        int n;
        int g;
        int exp_g;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'd0, '0);
        drive(1, 1'b1, 1'b0, 2'd1, '0);
        for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_RR_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            g = req1_ready ? 1 : 0;
            checks++;
            if ((req0_ready ^ req1_ready) !== 1'b1 || g != exp_g) begin
                errors++;
                $display("FAIL arb_grant%0d got ready=%b%b want grant %0d", k, req1_ready, req0_ready, exp_g);
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mem_full;
        int bad;
        bad = 0;
        @(negedge clk);
        mem_full = 1'b1;
        drive(1, 1'b1, 1'b0, 2'd3, '0);
        for (int c = 0; c < 5; c++) begin
            #1;
            if (req1_ready !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL full_stall got %0d bad cycles want 0", bad);
        end
        mem_full = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL full_release got ready=%b%b want 10", req1_ready, req0_ready);
        end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 2'd3) begin
            errors++; $display("FAIL full_issue got rd=%b addr=%0d want 1,3", mem_rd_en, mem_rd_addr);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== bank_data[3]) begin
            errors++; $display("FAIL full_rsp got v=%b rdata=%h want 1,%h", rsp1_valid, rsp1_rdata, bank_data[3]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        int stray;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'd1, '0);
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || rsp0_valid !== 1'b0 ||
            rsp1_valid !== 1'b0 || rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            errors++;
            $display("FAIL abort_outputs got busy=%b wr=%b rd=%b rsp=%b%b rd0=%h want all 0",
                     busy, mem_wr_en, mem_rd_en, rsp0_valid, rsp1_valid, rsp0_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rsp0_valid || rsp1_valid || mem_wr_en || mem_rd_en || busy) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL abort_quiet got %0d active cycles want 0", stray);
        end
        txn(0, 1'b0, 2'd1, '0, bank_data[1]);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_all_banks();
        test_arbitration();
        test_mem_full();
        test_reset_mid();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL exclusivity got %0d overlap cycles want 0", viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
